spm_cfg_seq: RTL and testbench

Configuration sequencer for the scratchpad bank-group array. It accepts SPM instruction words from a host over a valid/ready stream and replays them into the scratchpad's configuration buffer as `init` strobes. On `start`, it steps the scratchpad through the loaded contexts with one `run` strobe per context, holding each context for a programmable dwell time. It repeats the full context list a programmable number of passes, then signals `done`. It sits between the host/config port and the scratchpad's `inst`/`init`/`run` inputs.

---
 rtl/spm_cfg_seq.sv | 158 +++++++++++++++
 tb/tb_spm_cfg_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spm_cfg_seq.sv
// Configuration sequencer: loads SPM instruction words as init strobes, then steps contexts with
// run strobes for a programmable dwell and pass count. Optional perf counter: SPM_SEQ_PERF_EN.
module spm_cfg_seq #(
  parameter int unsigned INST_W = 24,
  parameter int unsigned DEPTH  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INST_W-1:0] cfg_inst,
  input  logic              cfg_last,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  dwell,
  input  logic [CNT_W-1:0]  loops,
  output logic [INST_W-1:0] inst,
  output logic              init,
  output logic              run,
  output logic [2:0]        ctx_idx,
  output logic [2:0]        n_ctx,
  output logic              busy,
  output logic              done
`ifdef SPM_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  typedef enum logic [1:0] {StIdle, StLoaded, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               init_q, init_d;
  logic               run_q, run_d;
  logic [2:0]         ctx_q, ctx_d;
  logic [2:0]         n_q, n_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic [CNT_W-1:0]   lcnt_q, lcnt_d;
`ifdef SPM_SEQ_PERF_EN
  logic [31:0]        perf_q, perf_d;
`endif

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    init_d  = 1'b0;
    run_d   = 1'b0;
    ctx_d   = ctx_q;
    n_d     = n_q;
    dcnt_d  = dcnt_q;
    dwell_d = dwell_q;
    lcnt_d  = lcnt_q;
`ifdef SPM_SEQ_PERF_EN
    perf_d  = perf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          inst_d = cfg_inst;
          init_d = 1'b1;
          n_d    = n_q + 3'd1;
          if (cfg_last || (n_q + 3'd1 == 3'(DEPTH))) state_d = StLoaded;
        end
      end
      StLoaded: begin
        if (clear) begin
          n_d     = 3'd0;
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
          dwell_d = (dwell == '0) ? CNT_W'(1) : dwell;
          lcnt_d  = (loops == '0) ? CNT_W'(1) : loops;
          ctx_d   = 3'd0;
          dcnt_d  = '0;
          run_d   = 1'b1;
`ifdef SPM_SEQ_PERF_EN
          perf_d  = '0;
`endif
        end
      end
      StRun: begin
`ifdef SPM_SEQ_PERF_EN
        if (perf_q != '1) perf_d = perf_q + 32'd1;
`endif
        if (abort) begin
          state_d = StLoaded;
          ctx_d   = 3'd0;
        end else if (dcnt_q == dwell_q - CNT_W'(1)) begin
          // Context finished: advance, wrap to the next pass, or complete.
          dcnt_d = '0;
          if (ctx_q == n_q - 3'd1) begin
            ctx_d = 3'd0;
            if (lcnt_q == CNT_W'(1)) begin
              state_d = StDone;
            end else begin
              lcnt_d = lcnt_q - CNT_W'(1);
              run_d  = 1'b1;
            end
          end else begin
            ctx_d = ctx_q + 3'd1;
            run_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + CNT_W'(1);
        end
      end
      StDone: state_d = StLoaded;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      inst_q  <= '0;
      init_q  <= 1'b0;
      run_q   <= 1'b0;
      ctx_q   <= 3'd0;
      n_q     <= 3'd0;
      dcnt_q  <= '0;
      dwell_q <= '0;
      lcnt_q  <= '0;
`ifdef SPM_SEQ_PERF_EN
      perf_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      init_q  <= init_d;
      run_q   <= run_d;
      ctx_q   <= ctx_d;
      n_q     <= n_d;
      dcnt_q  <= dcnt_d;
      dwell_q <= dwell_d;
      lcnt_q  <= lcnt_d;
`ifdef SPM_SEQ_PERF_EN
      perf_q  <= perf_d;
`endif
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign inst      = inst_q;
  assign init      = init_q;
  assign run       = run_q;
  assign ctx_idx   = ctx_q;
  assign n_ctx     = n_q;
`ifdef SPM_SEQ_PERF_EN
  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_spm_cfg_seq.sv
// Randomized bench for spm_cfg_seq; expected run behaviour is computed arithmetically from the
// loaded count, effective dwell and pass count.
module tb_spm_cfg_seq;
  localparam int INST_W = 24;
  localparam int DEPTH  = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid, cfg_ready, cfg_last, clear, start, abort;
  logic [INST_W-1:0] cfg_inst, inst;
  logic [CNT_W-1:0]  dwell, loops;
  logic              init, run, busy, done;
  logic [2:0]        ctx_idx, n_ctx;
`ifdef SPM_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_n    = 0;
  bit exp_loaded = 1'b0;
  logic [INST_W-1:0] exp_inst = '0;

  always #5 clk = ~clk;

  spm_cfg_seq #(.INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_inst(cfg_inst),
    .cfg_last(cfg_last), .clear(clear), .start(start), .abort(abort), .dwell(dwell),
    .loops(loops), .inst(inst), .init(init), .run(run), .ctx_idx(ctx_idx), .n_ctx(n_ctx),
    .busy(busy), .done(done)
`ifdef SPM_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_vals();
    check_eq("rst_ready", cfg_ready, 1);
    check_eq("rst_inst", inst, 0);
    check_eq("rst_init", init, 0);
    check_eq("rst_run", run, 0);
    check_eq("rst_ctx", ctx_idx, 0);
    check_eq("rst_nctx", n_ctx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
`ifdef SPM_SEQ_PERF_EN
    check_eq("rst_perf", perf_cycles, 0);
`endif
  endtask

  task automatic load_prog(input int nw, input bit use_last);
    logic [INST_W-1:0] w;
    bit acc;
    for (int i = 0; i < nw; i++) begin
      w   = INST_W'($urandom);
      acc = !exp_loaded;
      check_eq("cfg_ready", cfg_ready, acc);
      cfg_valid = 1'b1;
      cfg_inst  = w;
      cfg_last  = use_last && (i == nw - 1);
      // Control inputs are ignored while loading, but must stay quiet once loaded.
      start = acc ? 1'($urandom) : 1'b0;
      abort = acc ? 1'($urandom) : 1'b0;
      clear = acc ? 1'($urandom) : 1'b0;
      tick();
      check_eq("init", init, acc);
      if (acc) begin
        exp_inst = w;
        exp_n++;
        if (cfg_last || exp_n == DEPTH) exp_loaded = 1'b1;
      end
      check_eq("inst", inst, exp_inst);
      check_eq("n_ctx", n_ctx, exp_n);
      check_eq("no_busy_load", busy, 0);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    clear = 1'b0;
    tick();
    check_eq("init_off", init, 0);
    check_eq("inst_hold", inst, exp_inst);
    check_eq("ready_loaded", cfg_ready, !exp_loaded);
  endtask

  task automatic clear_prog();
    clear = 1'b1;
    start = 1'($urandom);
    tick();
    clear = 1'b0;
    start = 1'b0;
    exp_n = 0;
    exp_loaded = 1'b0;
    check_eq("clr_nctx", n_ctx, 0);
    check_eq("clr_ready", cfg_ready, 1);
    check_eq("clr_busy", busy, 0);
  endtask

  task automatic do_run(input int dw, input int lp, input int abort_at);
    int d, l, total;
    bit aborted;
    d = (dw == 0) ? 1 : dw;
    l = (lp == 0) ? 1 : lp;
    total = exp_n * d * l;
    aborted = 1'b0;
    dwell = CNT_W'(dw);
    loops = CNT_W'(lp);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < total; k++) begin
      check_eq("busy", busy, 1);
      check_eq("run", run, (k % d) == 0);
      check_eq("ctx_idx", ctx_idx, (k / d) % exp_n);
      check_eq("init_run", init, 0);
      check_eq("done_early", done, 0);
      dwell = CNT_W'($urandom);
      loops = CNT_W'($urandom);
      start = 1'($urandom);
      clear = 1'($urandom);
      if (k == abort_at) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      tick();
      abort = 1'b0;
      start = 1'b0;
      clear = 1'b0;
      if (aborted) break;
    end
    if (aborted) begin
      check_eq("ab_busy", busy, 0);
      check_eq("ab_done", done, 0);
      check_eq("ab_run", run, 0);
      check_eq("ab_ready", cfg_ready, 0);
`ifdef SPM_SEQ_PERF_EN
      check_eq("ab_perf", perf_cycles, abort_at + 1);
`endif
    end else begin
      check_eq("done", done, 1);
      check_eq("done_busy", busy, 0);
      check_eq("done_run", run, 0);
`ifdef SPM_SEQ_PERF_EN
      check_eq("perf", perf_cycles, total);
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      check_eq("done_pulse", done, 0);
      check_eq("post_busy", busy, 0);
      check_eq("post_ready", cfg_ready, 0);
      check_eq("post_nctx", n_ctx, exp_n);
    end
  endtask

  initial begin
    int dw, lp, ab, total, nw;
    rst = 1'b0;
    cfg_valid = 1'b0;
    cfg_inst = '0;
    cfg_last = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    dwell = '0;
    loops = '0;
    tick();
    tick();
    check_reset_vals();
    rst = 1'b1;
    tick();
    check_eq("idle_ready", cfg_ready, 1);

    load_prog(3, 1'b1);
    do_run(2, 2, -1);

    clear_prog();
    load_prog(2, 1'b1);
    do_run(0, 0, -1);

    clear_prog();
    load_prog(6, 1'b0);
    do_run(1, 1, exp_n - 1);
    do_run(1, 1, -1);

    clear_prog();
    load_prog(3, 1'b1);
    do_run(4, 1, -1);

    for (int it = 0; it < 25; it++) begin
      clear_prog();
      nw = $urandom_range(1, 7);
      load_prog(nw, (nw < DEPTH) ? 1'b1 : 1'($urandom));
      dw = $urandom_range(0, 4);
      lp = $urandom_range(0, 3);
      total = exp_n * ((dw == 0) ? 1 : dw) * ((lp == 0) ? 1 : lp);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, total - 1) : -1;
      do_run(dw, lp, ab);
    end

    dwell = CNT_W'(3);
    loops = CNT_W'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_reset_vals();
    rst = 1'b1;
    exp_n = 0;
    exp_loaded = 1'b0;
    exp_inst = '0;
    tick();
    check_eq("rerst_ready", cfg_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
